// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receiver and the planned transmitter.
package uart_pkg;

    // Receiver phases. The transmitter walks through the same phases of a frame.
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

    // 100 MHz system clock divided down to 115200 baud.
    localparam int CLKS_PER_BIT_115200 = 868;

endpackage : uart_pkg

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver (LSB first, idle-high line) with a one-deep
// holding register on a valid/ready handshake and single-cycle error pulses.
// The rx input must already be synchronized to clk by the parent.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    // Reject parameter values the counters and the mid-bit sampling cannot support.
    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
        $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_rx: DATA_BITS must be in the range 5..8");
    end

    uart_rx_state_t       state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_err_q, overrun_err_d;
    logic                 rx_q;
    logic                 start_edge;

    // A start is a falling edge; rx_q resets low so a line held low across reset is ignored.
    assign start_edge = rx_q & ~rx;

    // Next-state logic: baud counting, bit sampling, delivery and error pulses.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        frame_err_d   = 1'b0;
        overrun_err_d = 1'b0;

        // Consumer handshake; a delivery below in the same cycle can re-set valid.
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end

            START: begin
                if (cnt_q == CNT_MID) begin
                    // Mid start bit: still low means a real frame, high means a glitch.
                    if (!rx) begin
                        state_d   = DATA;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    // LSB arrives first, so shifting in from the top leaves bit 0 at index 0.
                    shift_d = {rx, shift_q[DATA_BITS-1:1]};
                    cnt_d   = '0;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (rx) begin
                        // Holding register is free, or is being emptied this very cycle.
                        if (!rx_valid_q || rx_ready) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_err_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            rx_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
            rx_q          <= rx;
        end
        // NOTE: the shift register is left out of reset; every bit is overwritten before it is delivered.
        shift_q <= shift_d;
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenarios plus randomized traffic, checked every cycle against
// a waveform-level model that decodes the line from sample instants measured from
// each start edge.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int DB   = 8;
    localparam int HALF = CPB / 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          rx_ready = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          overrun_err;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Cycle index: the value of cyc before an edge is the number of that edge.
    int cyc = 0;

    // Model state: start edge of the frame in progress (-1 = none), previous line value.
    int            m_fs = -1;
    logic          m_prev = 1'b0;
    logic [DB-1:0] m_bits = '0;
    logic [DB-1:0] m_data = '0;
    logic          m_valid = 1'b0;
    logic          m_ferr = 1'b0;
    logic          m_ovr = 1'b0;

    // Observation counters for the directed literal checks.
    int   n_ferr = 0;
    int   n_ovr = 0;
    int   rise_c = -1;
    logic last_valid = 1'b0;
    bit   rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Decode the line: glitch test at HALF after the start edge, data bit j-1 and the
    // stop bit at HALF + j*CPB (j = 1..DB and DB+1).
    task automatic model_update();
        int off;
        if (!rst_n) begin
            m_fs    = -1;
            m_prev  = 1'b0;
            m_data  = '0;
            m_valid = 1'b0;
            m_ferr  = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            if (m_valid && rx_ready) m_valid = 1'b0;
            if (m_fs < 0) begin
                if (m_prev && !rx) m_fs = cyc;
            end else begin
                off = cyc - m_fs;
                if (off == HALF) begin
                    if (rx) m_fs = -1;
                end else if (off > HALF && (off - HALF) % CPB == 0) begin
                    if ((off - HALF) / CPB <= DB) begin
                        m_bits[(off - HALF) / CPB - 1] = rx;
                    end else begin
                        m_fs = -1;
                        if (!rx) begin
                            m_ferr = 1'b1;
                        end else if (m_valid) begin
                            m_ovr = 1'b1;
                        end else begin
                            m_data  = m_bits;
                            m_valid = 1'b1;
                        end
                    end
                end
            end
            m_prev = rx;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
        check("rx_valid", {31'd0, rx_valid}, {31'd0, m_valid});
        check("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
        check("overrun_err", {31'd0, overrun_err}, {31'd0, m_ovr});
        if (m_valid) check("rx_data", {24'd0, rx_data}, {24'd0, m_data});
        if (frame_err === 1'b1) n_ferr++;
        if (overrun_err === 1'b1) n_ovr++;
        if (rx_valid === 1'b1 && !last_valid && rise_c < 0) rise_c = cyc;
        last_valid = rx_valid;
        if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic line(input logic v, input int n);
        rx = v;
        repeat (n) tick();
    endtask

    // One frame; optionally raise rx_ready exactly in the stop-sample (delivery) cycle.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input bit ready_pulse);
        line(1'b0, CPB);
        for (int i = 0; i < DB; i++) line(d[i], CPB);
        line(stop, HALF);
        if (ready_pulse) rx_ready = 1'b1;
        tick();
        if (ready_pulse) rx_ready = 1'b0;
        repeat (CPB - HALF - 1) tick();
    endtask

    task automatic ack();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    int start_c;

    initial begin
        // Reset with the line idle.
        rx = 1'b1;
        repeat (3) tick();
        check("reset_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_data", {24'd0, rx_data}, 32'd0);
        rst_n = 1'b1;

        // 0xA5 with back-pressure: latency and data pinned by hand.
        line(1'b1, 5);
        rise_c  = -1;
        start_c = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        check("latency_a5", rise_c - start_c, 32'd153);
        check("data_a5", {24'd0, rx_data}, 32'h0000_00A5);
        ack();
        check("valid_after_ack", {31'd0, rx_valid}, 32'd0);

        // Back-to-back with no consumer: second byte dropped with one overrun pulse.
        n_ovr = 0;
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0);
        check("overrun_keep_data", {24'd0, rx_data}, 32'h0000_003C);
        check("overrun_pulses", n_ovr, 32'd1);
        ack();

        // Same pair, consumer accepts exactly in the second delivery cycle.
        line(1'b1, 2);
        n_ovr = 0;
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b1);
        check("same_cycle_data", {24'd0, rx_data}, 32'h0000_00C3);
        check("same_cycle_valid", {31'd0, rx_valid}, 32'd1);
        check("same_cycle_no_ovr", n_ovr, 32'd0);
        ack();

        // Stop bit low: one frame_err, nothing delivered; then a clean 0x12.
        n_ferr = 0;
        send_frame(8'h55, 1'b0, 1'b0);
        line(1'b1, 20);
        check("ferr_pulses", n_ferr, 32'd1);
        check("ferr_no_valid", {31'd0, rx_valid}, 32'd0);
        send_frame(8'h12, 1'b1, 1'b0);
        check("after_ferr_data", {24'd0, rx_data}, 32'h0000_0012);
        ack();

        // 4-cycle glitch; a new start edge at cycle 9 must be accepted.
        n_ferr = 0;
        n_ovr  = 0;
        line(1'b1, 5);
        line(1'b0, 4);
        line(1'b1, 5);
        check("glitch_no_ferr", n_ferr, 32'd0);
        check("glitch_no_valid", {31'd0, rx_valid}, 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0);
        check("after_glitch_data", {24'd0, rx_data}, 32'h0000_005A);

        // Reset in the middle of data bit 3 of 0xFF, line low across release.
        line(1'b1, 3);
        line(1'b0, CPB);
        line(1'b1, 3 * CPB + HALF);
        rx    = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        check("midreset_valid", {31'd0, rx_valid}, 32'd0);
        check("midreset_data", {24'd0, rx_data}, 32'd0);
        check("midreset_ferr", {31'd0, frame_err}, 32'd0);
        check("midreset_ovr", {31'd0, overrun_err}, 32'd0);
        rst_n  = 1'b1;
        n_ferr = 0;
        line(1'b0, 20);
        line(1'b1, 5);
        check("low_release_no_ferr", n_ferr, 32'd0);
        check("low_release_no_valid", {31'd0, rx_valid}, 32'd0);
        send_frame(8'h81, 1'b1, 1'b0);
        check("after_reset_data", {24'd0, rx_data}, 32'h0000_0081);
        ack();

        // Break: 400 low cycles produce exactly one frame error.
        n_ferr = 0;
        line(1'b0, 400);
        line(1'b1, 20);
        check("break_ferr_pulses", n_ferr, 32'd1);
        check("break_no_valid", {31'd0, rx_valid}, 32'd0);

        // Randomized traffic with random consumer back-pressure.
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                line(1'b0, $urandom_range(1, 12));
                line(1'b1, $urandom_range(1, 12));
            end else begin
                send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 7) != 0), 1'b0);
                line(1'b1, $urandom_range(0, 20));
            end
        end
        rand_ready = 1'b0;
        rx_ready   = 1'b1;
        line(1'b1, 3 * CPB * (DB + 2));
        check("drain_valid", {31'd0, rx_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx
